mux4to1_arb: RTL

Round-robin arbiter and sequencer that shares one 4-to-1 datapath multiplexer among four requesters. It accepts packets of one or more beats from requesters 0-3 over valid/ready handshakes and grants the mux to one requester at a time. It drives the 2-bit mux select and holds the grant until that requester's last beat has passed. It registers the selected beat into a single-entry output stage that feeds the downstream consumer, such as a register-file write port or an ALU operand bus.

---
 rtl/mux4to1_arb.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mux4to1_arb.sv
// Round-robin arbiter sharing one 4-to-1 payload mux among four packet requesters,
// with a single-entry registered output stage. Optional watchdog: MUX4TO1_ARB_TIMEOUT_EN.
module mux4to1_arb #(
  parameter int SIZE    = 8,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [3:0]      last,
  input  logic [SIZE-1:0] data0,
  input  logic [SIZE-1:0] data1,
  input  logic [SIZE-1:0] data2,
  input  logic [SIZE-1:0] data3,
  output logic [3:0]      ready,
  output logic [1:0]      sel,
  output logic            out_valid,
  output logic [SIZE-1:0] out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic            busy,
  output logic            timeout_err
);

  // Handshake: a beat moves on any rising edge where req[i] & ready[i] are both high;
  // the output beat moves on any rising edge where out_valid & out_ready are both high.

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mux4to1_arb: TIMEOUT must lie in 2..255");
  end

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      winner;
  logic [1:0]      idx;
  logic            found;
  logic            any_req;
  logic            space;
  logic            xfer;
  logic            xfer_last;
  logic            timeout_hit;
  logic [SIZE-1:0] mux_data;

  assign any_req = |req;
  assign space   = !out_valid || out_ready;
  assign busy    = (state_q == HOLD);
  assign sel     = sel_q;

  // Only the held grant and output-stage space feed ready, never req.
  assign ready     = (busy && space) ? (4'b0001 << sel_q) : 4'b0000;
  assign xfer      = busy && space && req[sel_q];
  assign xfer_last = xfer && last[sel_q];

  always_comb begin
    winner = ptr_q;
    idx    = ptr_q;
    found  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    mux_data = data0;
    case (sel_q)
      2'd0: mux_data = data0;
      2'd1: mux_data = data1;
      2'd2: mux_data = data2;
      2'd3: mux_data = data3;
      default: mux_data = data0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d   = winner;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // sel is left alone on release so the mux stays quiet until the next grant.
        if (xfer_last || timeout_hit) begin
          state_d = IDLE;
          ptr_d   = sel_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_last  <= last[sel_q];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX4TO1_ARB_TIMEOUT_EN
  logic [7:0] idle_cnt;
  logic       timeout_q;

  // Counts consecutive cycles the grant holder leaves req low; reads 0 on every HOLD entry.
  assign timeout_hit = busy && !req[sel_q] && (idle_cnt == 8'(TIMEOUT - 1));
  assign timeout_err = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (!busy || req[sel_q] || timeout_hit) begin
        idle_cnt <= 8'd0;
      end else begin
        idle_cnt <= idle_cnt + 8'd1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
